apb_master_arbiter: RTL and testbench

- Shares one APB bus between REQ_NUM simple request/response masters (bridge-side CPU path, DMA, debug) using round-robin arbitration.
- Sequences the APB IDLE/SETUP/ACCESS protocol and decodes the slave one-hot psel from the address.
- Returns read data and error to the granted master.
- Adds decode-error and timeout protection, so a missing or hung slave can never lock the bus.

---
 rtl/apb_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/apb_master_arbiter.sv | 135 +++++++++++++
 tb/tb_apb_master_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared FSM states and slave-index decode for the APB master arbiter
package apb_arb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    localparam int SLV_IDX_W = 12;
    typedef struct packed {
        logic                 valid;
        logic [SLV_IDX_W-1:0] idx;
    } slv_dec_t;
    function automatic slv_dec_t slv_decode(input logic [SLV_IDX_W-1:0] field, input int pslv_num);
        slv_dec_t d;
        d.idx   = field;
        d.valid = int'(field) < pslv_num;
        return d;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick starting after the last granted requester
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_req,
    input  logic          i_update,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);
    logic [IW-1:0] r_last;
    logic          w_found;
    always_comb begin
        w_found = 1'b0;
        o_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!w_found && i_req[IW'((int'(r_last) + k) % N)]) begin
                w_found = 1'b1;
                o_idx   = IW'((int'(r_last) + k) % N);
            end
        end
    end
    assign o_grant = w_found ? N'(1) << o_idx : '0;
    // Starting at N-1 gives master 0 first priority out of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_last <= IW'(N - 1);
        else if (i_update)
            r_last <= o_idx;
    end
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB bus among REQ_NUM requesters with decode-error and timeout protection
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int REQ_NUM     = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int PADDR_WIDTH = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int PSLV_NUM    = 5,
    parameter int TIMEOUT     = 255
) (
    input  logic                             pclk,
    input  logic                             prst,
    input  logic                             pclken,
    input  logic [REQ_NUM-1:0]               req_valid,
    input  logic [REQ_NUM*ADDR_WIDTH-1:0]    req_addr,
    input  logic [REQ_NUM-1:0]               req_write,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]    req_wdata,
    input  logic [REQ_NUM*DATA_WIDTH/8-1:0]  req_strb,
    output logic [REQ_NUM-1:0]               req_ready,
    output logic [DATA_WIDTH-1:0]            req_rdata,
    output logic                             req_err,
    output logic [$clog2(REQ_NUM)-1:0]       grant_id,
    output logic                             busy,
    output logic [PADDR_WIDTH-1:0]           paddr,
    output logic [PSLV_NUM-1:0]              psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [DATA_WIDTH-1:0]            pwdata,
    output logic [DATA_WIDTH/8-1:0]          pstrb,
    input  logic [PSLV_NUM-1:0]              pready_i,
    input  logic [PSLV_NUM*DATA_WIDTH-1:0]   prdata_i,
    input  logic [PSLV_NUM-1:0]              pslverr_i
);
    localparam int GW = $clog2(REQ_NUM);
    localparam int SW = PSLV_NUM > 1 ? $clog2(PSLV_NUM) : 1;
    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;

    state_t                 r_state, w_next;
    logic [GW-1:0]          r_grant, w_gidx;
    logic [REQ_NUM-1:0]     w_gnt_oh;
    logic [SW-1:0]          r_sidx;
    logic [PADDR_WIDTH-1:0] r_paddr;
    logic                   r_pwrite, r_err;
    logic [DATA_WIDTH-1:0]  r_pwdata, r_rdata;
    logic [BW-1:0]          r_pstrb;
    logic [CW-1:0]          r_cnt;
    logic [ADDR_WIDTH-1:0]  w_addr;
    slv_dec_t               w_dec;
    logic                   w_take, w_wr, w_rdy, w_done, w_wait, w_tout;

    rr_arbiter #(.N(REQ_NUM)) u_rr (
        .i_clk    (pclk),
        .i_rst    (prst),
        .i_req    (req_valid),
        .i_update (w_take),
        .o_grant  (w_gnt_oh),
        .o_idx    (w_gidx)
    );

    assign w_take = r_state == IDLE && pclken && |req_valid;
    assign w_addr = req_addr[w_gidx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_dec  = slv_decode(w_addr[PADDR_WIDTH+SLV_IDX_W-1:PADDR_WIDTH], PSLV_NUM);
    assign w_wr   = |(req_write & w_gnt_oh);
    assign w_rdy  = pready_i[r_sidx];
    assign w_done = r_state == ACCESS && pclken && w_rdy;
    assign w_wait = r_state == ACCESS && pclken && !w_rdy;
    assign w_tout = w_wait && TIMEOUT != 0 && r_cnt == CW'(TIMEOUT - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_take) w_next = w_dec.valid ? SETUP : RESP;
            SETUP:   if (pclken) w_next = ACCESS;
            ACCESS:  if (w_done || w_tout) w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (prst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            r_grant  <= '0;
            r_sidx   <= '0;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_take) begin
                r_grant  <= w_gidx;
                r_sidx   <= SW'(w_dec.idx);
                r_paddr  <= w_addr[PADDR_WIDTH-1:0];
                r_pwrite <= w_wr;
                r_pwdata <= req_wdata[w_gidx*DATA_WIDTH +: DATA_WIDTH];
                r_pstrb  <= w_wr ? req_strb[w_gidx*BW +: BW] : '0;
                r_rdata  <= '0;
                r_err    <= !w_dec.valid;
                r_cnt    <= '0;
            end
            if (w_done) begin
                r_rdata <= r_pwrite ? '0 : prdata_i[r_sidx*DATA_WIDTH +: DATA_WIDTH];
                r_err   <= pslverr_i[r_sidx];
            end
            if (w_tout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end else if (w_wait) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign req_ready = r_state == RESP ? REQ_NUM'(1) << r_grant : '0;
    assign req_rdata = r_rdata;
    assign req_err   = r_err;
    assign grant_id  = r_grant;
    assign busy      = r_state != IDLE;
    assign paddr     = r_paddr;
    assign psel      = (r_state == SETUP || r_state == ACCESS) ? PSLV_NUM'(1) << r_sidx : '0;
    assign penable   = r_state == ACCESS;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign pstrb     = r_pstrb;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed vectors with hand-computed expectations for apb_master_arbiter
module tb_apb_master_arbiter;
    localparam int RN = 2, AW = 32, PW = 16, DW = 32, SN = 5, TO = 8, BW = DW / 8;

    logic              pclk = 1'b0, prst = 1'b1, pclken = 1'b1;
    logic [RN-1:0]     req_valid = '0, req_write = '0;
    logic [RN*AW-1:0]  req_addr = '0;
    logic [RN*DW-1:0]  req_wdata = '0;
    logic [RN*BW-1:0]  req_strb = '0;
    logic [RN-1:0]     req_ready;
    logic [DW-1:0]     req_rdata;
    logic              req_err;
    logic [0:0]        grant_id;
    logic              busy;
    logic [PW-1:0]     paddr;
    logic [SN-1:0]     psel;
    logic              penable, pwrite;
    logic [DW-1:0]     pwdata;
    logic [BW-1:0]     pstrb;
    logic [SN-1:0]     pready_i = '1, pslverr_i = '0;
    logic [SN*DW-1:0]  prdata_i = '0;
    int n_chk = 0, n_err = 0;

    always #5 pclk = ~pclk;

    apb_master_arbiter #(
        .REQ_NUM(RN), .ADDR_WIDTH(AW), .PADDR_WIDTH(PW),
        .DATA_WIDTH(DW), .PSLV_NUM(SN), .TIMEOUT(TO)
    ) dut (
        .pclk(pclk), .prst(prst), .pclken(pclken),
        .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_ready(req_ready),
        .req_rdata(req_rdata), .req_err(req_err), .grant_id(grant_id), .busy(busy),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pready_i(pready_i),
        .prdata_i(prdata_i), .pslverr_i(pslverr_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int m, input logic [AW-1:0] a, input logic w,
                           input logic [DW-1:0] d, input logic [BW-1:0] s);
        req_addr[m*AW +: AW]  = a;
        req_write[m]          = w;
        req_wdata[m*DW +: DW] = d;
        req_strb[m*BW +: BW]  = s;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_apb"}, {paddr, psel, penable, pwrite, pstrb}, 0);
        check({tag, "_pwdata"}, pwdata, 0);
        check({tag, "_req"}, {req_ready, req_rdata, req_err, grant_id, busy}, 0);
    endtask

    int exp_g[4] = '{0, 1, 0, 1};

    initial begin
        step(2);
        prst = 1'b0;
        check_reset("reset");

        // single zero-wait write from master 0
        set_req(0, 32'h4001_0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
        req_valid = 2'b01;
        step();
        check("t1_psel", psel, 5'b00010);
        check("t1_paddr", paddr, 16'h0010);
        check("t1_setup_pen", penable, 0);
        check("t1_wr", {pwrite, pstrb, pwdata}, {1'b1, 4'hF, 32'hDEAD_BEEF});
        req_valid = '0;
        step();
        check("t1_access", {psel, penable}, {5'b00010, 1'b1});
        step();
        check("t1_ready", {req_ready, req_err}, {2'b01, 1'b0});
        step();
        check("t1_idle", {req_ready, busy}, 0);

        // read from slave 3 with four wait states, other slaves ready
        set_req(1, 32'h4003_0004, 1'b0, 32'h0, 4'hF);
        prdata_i[3*DW +: DW] = 32'h1234_5678;
        pready_i = 5'b10111;
        req_valid = 2'b10;
        step();
        check("t2_setup", {psel, grant_id, pstrb}, {5'b01000, 1'b1, 4'h0});
        req_valid = '0;
        step(4);
        check("t2_wait", {penable, req_ready}, {1'b1, 2'b00});
        step();
        pready_i = '1;
        check("t2_wait_last", {penable, req_ready}, {1'b1, 2'b00});
        step();
        check("t2_ready", {req_ready, req_err}, {2'b10, 1'b0});
        check("t2_rdata", req_rdata, 32'h1234_5678);
        step();
        check("t2_idle", req_ready, 0);

        // contention: alternate grants, one-cycle ready pulses
        set_req(0, 32'h4001_0010, 1'b1, 32'h1111_1111, 4'h1);
        set_req(1, 32'h4002_0020, 1'b1, 32'h2222_2222, 4'h2);
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            step();
            check("t3_grant", grant_id, exp_g[t]);
            check("t3_paddr", paddr, exp_g[t] == 0 ? 16'h0010 : 16'h0020);
            step(2);
            check("t3_ready", req_ready, exp_g[t] == 0 ? 2'b01 : 2'b10);
            step();
            check("t3_pulse", req_ready, 0);
        end
        req_valid = '0;

        // decode error: slave index 5 is out of range
        set_req(0, 32'h4005_0000, 1'b0, 32'h0, 4'h0);
        req_valid = 2'b01;
        step();
        check("t4_resp", {req_ready, req_err, psel, busy}, {2'b01, 1'b1, 5'b0, 1'b1});
        check("t4_rdata", req_rdata, 0);
        req_valid = '0;
        step();
        check("t4_idle", {req_ready, busy}, 0);

        // timeout: slave 4 never ready
        set_req(1, 32'h4004_0000, 1'b0, 32'h0, 4'h0);
        prdata_i[4*DW +: DW] = 32'hFFFF_FFFF;
        pready_i = 5'b01111;
        req_valid = 2'b10;
        step();
        check("t5_setup", psel, 5'b10000);
        req_valid = '0;
        step(8);
        check("t5_last_access", {psel, penable, req_ready}, {5'b10000, 1'b1, 2'b00});
        step();
        check("t5_resp", {req_ready, req_err, psel, penable}, {2'b10, 1'b1, 5'b0, 1'b0});
        check("t5_rdata", req_rdata, 0);
        pready_i = '1;
        step();
        check("t5_idle", busy, 0);

        // pclken gating, then reset during ACCESS
        set_req(0, 32'h4001_0010, 1'b1, 32'hCAFE_F00D, 4'h3);
        req_valid = 2'b01;
        pclken = 1'b0;
        step();
        check("t6_hold_idle", {busy, psel}, 0);
        pclken = 1'b1;
        step();
        check("t6_setup", {busy, psel, penable}, {1'b1, 5'b00010, 1'b0});
        req_valid = '0;
        pclken = 1'b0;
        step();
        check("t6_hold_setup", {psel, penable}, {5'b00010, 1'b0});
        pclken = 1'b1;
        step();
        check("t6_access", penable, 1);
        pclken = 1'b0;
        step();
        check("t6_hold_access", {penable, req_ready}, {1'b1, 2'b00});
        prst = 1'b1;
        step();
        check_reset("t6_reset");
        prst = 1'b0;
        pclken = 1'b1;
        set_req(1, 32'h4002_0020, 1'b1, 32'h3333_3333, 4'hF);
        req_valid = 2'b11;
        step();
        check("t6_first_grant", {grant_id, psel}, {1'b0, 5'b00010});
        req_valid = '0;
        step(2);
        check("t6_ready", req_ready, 2'b01);
        step();
        check("t6_end", {req_ready, busy}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
